// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned BYTE_W = 8;

   typedef enum logic {
      SZ_BYTE = 1'b0,
      SZ_HALF = 1'b1
   } size_e;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LD_WAIT = 2'd1,
      RMW     = 2'd2
   } state_e;

   // Request fields kept for the second cycle of a load or byte store
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      size_e             size;
      logic              is_unsigned;
      logic [BYTE_W-1:0] wbyte;
   } req_cap_t;

   // Byte address to dmem word address
   function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] a);
      return {1'b0, a[ADDR_W-1:1]};
   endfunction

endpackage

// File: rtl/lsu_if.sv
// Core request/response and dmem port bundle around the LSU.
interface lsu_if;

   logic                         req_valid_i;
   logic                         req_ready_o;
   logic                         req_we_i;
   logic                         req_size_i;
   logic                         req_unsigned_i;
   logic [lsu_pkg::ADDR_W-1:0]   req_addr_i;
   logic [lsu_pkg::DATA_W-1:0]   req_wdata_i;
   logic                         resp_valid_o;
   logic [lsu_pkg::DATA_W-1:0]   resp_rdata_o;
   logic                         resp_err_o;
   logic [lsu_pkg::ADDR_W-1:0]   dmem_addr_o;
   logic [lsu_pkg::DATA_W-1:0]   dmem_wdata_o;
   logic                         dmem_we_o;
   logic                         dmem_re_o;
   logic [lsu_pkg::DATA_W-1:0]   dmem_rdata_i;

   // LSU side
   modport slave (
      input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
      input  dmem_rdata_i,
      output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
      output dmem_addr_o, dmem_wdata_o, dmem_we_o, dmem_re_o
   );

   // Core and memory side
   modport master (
      output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
      output dmem_rdata_i,
      input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
      input  dmem_addr_o, dmem_wdata_o, dmem_we_o, dmem_re_o
   );

endinterface

// File: rtl/lsu_fmt.sv
// Load lane select/extension and store byte merge (purely combinational).
module lsu_fmt
   import lsu_pkg::*;
(
   input  logic [DATA_W-1:0] rdata_i,
   input  logic              lane_i,
   input  size_e             size_i,
   input  logic              unsigned_i,
   input  logic [BYTE_W-1:0] wbyte_i,
   output logic [DATA_W-1:0] load_o,
   output logic [DATA_W-1:0] merge_o
);

   logic [BYTE_W-1:0] lane_byte;

   // Pick the addressed byte, extend it, or pass a half through
   always_comb begin
      lane_byte = lane_i ? rdata_i[DATA_W-1:BYTE_W] : rdata_i[BYTE_W-1:0];
      load_o    = rdata_i;
      if (size_i == SZ_BYTE) begin
         if (unsigned_i) load_o = {{(DATA_W-BYTE_W){1'b0}}, lane_byte};
         else            load_o = {{(DATA_W-BYTE_W){lane_byte[BYTE_W-1]}}, lane_byte};
      end
   end

   // Replace the addressed byte of the read word with the store byte
   always_comb begin
      merge_o = lane_i ? {wbyte_i, rdata_i[BYTE_W-1:0]}
                       : {rdata_i[DATA_W-1:BYTE_W], wbyte_i};
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: core MEM-stage requests to a word-wide dmem with no byte enables.
module lsu
   import lsu_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   lsu_if.slave  bus
);

   state_e              state_q, state_d;
   req_cap_t            rq_q, rq_d;
   logic                resp_valid_q, resp_valid_d;
   logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
   logic                resp_err_q, resp_err_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;

   logic                ready_c;
   logic                accept_c;
   logic                dmem_we_c;
   logic                dmem_re_c;
   logic [ADDR_W-1:0]   dmem_addr_c;
   logic [DATA_W-1:0]   dmem_wdata_c;
   logic [DATA_W-1:0]   load_c;
   logic [DATA_W-1:0]   merge_c;

   lsu_fmt u_fmt (
      .rdata_i    (bus.dmem_rdata_i),
      .lane_i     (rq_q.addr[0]),
      .size_i     (rq_q.size),
      .unsigned_i (rq_q.is_unsigned),
      .wbyte_i    (rq_q.wbyte),
      .load_o     (load_c),
      .merge_o    (merge_c)
   );

   assign ready_c  = (state_q == IDLE) && rst_n;
   assign accept_c = bus.req_valid_i && ready_c;

   // Next state, dmem strobes and response
   always_comb begin
      state_d      = state_q;
      rq_d         = rq_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = '0;
      resp_err_d   = 1'b0;
      dmem_we_c    = 1'b0;
      dmem_re_c    = 1'b0;
      dmem_wdata_c = '0;
      dmem_addr_c  = addr_q;

      unique case (state_q)
         IDLE: begin
            if (accept_c) begin
               rq_d.addr        = bus.req_addr_i;
               rq_d.size        = size_e'(bus.req_size_i);
               rq_d.is_unsigned = bus.req_unsigned_i;
               rq_d.wbyte       = bus.req_wdata_i[BYTE_W-1:0];
               if ((size_e'(bus.req_size_i) == SZ_HALF) && bus.req_addr_i[0]) begin
                  // Misaligned half: error response, dmem untouched
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else if (bus.req_we_i && (size_e'(bus.req_size_i) == SZ_HALF)) begin
                  dmem_we_c    = 1'b1;
                  dmem_wdata_c = bus.req_wdata_i;
                  dmem_addr_c  = word_addr(bus.req_addr_i);
                  resp_valid_d = 1'b1;
               end else begin
                  // Load, or the read half of a byte store
                  dmem_re_c    = 1'b1;
                  dmem_addr_c  = word_addr(bus.req_addr_i);
                  state_d      = bus.req_we_i ? RMW : LD_WAIT;
               end
            end
         end
         LD_WAIT: begin
            resp_valid_d = 1'b1;
            resp_rdata_d = load_c;
            state_d      = IDLE;
         end
         RMW: begin
            dmem_we_c    = 1'b1;
            dmem_wdata_c = merge_c;
            dmem_addr_c  = word_addr(rq_q.addr);
            resp_valid_d = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Reset kills any in-flight write at once
      if (!rst_n) begin
         dmem_we_c    = 1'b0;
         dmem_re_c    = 1'b0;
         dmem_wdata_c = '0;
      end

      addr_d = dmem_addr_c;
   end

   // State and response registers, synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         rq_q         <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
         addr_q       <= '0;
      end else begin
         state_q      <= state_d;
         rq_q         <= rq_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
         addr_q       <= addr_d;
      end
   end

   assign bus.req_ready_o  = ready_c;
   assign bus.resp_valid_o = resp_valid_q;
   assign bus.resp_rdata_o = resp_rdata_q;
   assign bus.resp_err_o   = resp_err_q;
   assign bus.dmem_addr_o  = dmem_addr_c;
   assign bus.dmem_wdata_o = dmem_wdata_c;
   assign bus.dmem_we_o    = dmem_we_c;
   assign bus.dmem_re_o    = dmem_re_c;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu against a 1-cycle registered-read dmem model.
module tb_lsu;

   logic clk = 1'b0;
   logic rst_n;
   int   n_chk  = 0;
   int   n_pass = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   lsu_if bus ();

   lsu dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // dmem: write at the edge, registered read, 0 when not reading
   logic [15:0] mem [256];
   always @(posedge clk) begin
      if (bus.dmem_we_o) mem[bus.dmem_addr_o[7:0]] <= bus.dmem_wdata_o;
      bus.dmem_rdata_i <= bus.dmem_re_o ? mem[bus.dmem_addr_o[7:0]] : 16'h0000;
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic we, input logic size, input logic uns,
                          input logic [15:0] addr, input logic [15:0] wdata);
      bus.req_valid_i    = 1'b1;
      bus.req_we_i       = we;
      bus.req_size_i     = size;
      bus.req_unsigned_i = uns;
      bus.req_addr_i     = addr;
      bus.req_wdata_i    = wdata;
   endtask

   task automatic clr_req();
      bus.req_valid_i    = 1'b0;
      bus.req_we_i       = 1'b0;
      bus.req_size_i     = 1'b0;
      bus.req_unsigned_i = 1'b0;
      bus.req_addr_i     = 16'h0000;
      bus.req_wdata_i    = 16'h0000;
   endtask

   // Aligned half store: write in the accept cycle, response next cycle
   task automatic do_hstore(input string tag, input logic [15:0] addr, input logic [15:0] data);
      set_req(1'b1, 1'b1, 1'b0, addr, data);
      #1;
      chk({tag, "_ready"}, 16'(bus.req_ready_o), 16'h1);
      chk({tag, "_we"},    16'(bus.dmem_we_o),   16'h1);
      chk({tag, "_re"},    16'(bus.dmem_re_o),   16'h0);
      chk({tag, "_addr"},  bus.dmem_addr_o,      addr >> 1);
      chk({tag, "_wdata"}, bus.dmem_wdata_o,     data);
      step();
      clr_req();
      #1;
      chk({tag, "_rv"},    16'(bus.resp_valid_o), 16'h1);
      chk({tag, "_rerr"},  16'(bus.resp_err_o),   16'h0);
      chk({tag, "_rdata"}, bus.resp_rdata_o,      16'h0000);
   endtask

   // Load: read at N, LD_WAIT at N+1, response at N+2
   task automatic do_load(input string tag, input logic [15:0] addr, input logic size,
                          input logic uns, input logic [15:0] exp);
      set_req(1'b0, size, uns, addr, 16'h0000);
      #1;
      chk({tag, "_re"},   16'(bus.dmem_re_o), 16'h1);
      chk({tag, "_we"},   16'(bus.dmem_we_o), 16'h0);
      chk({tag, "_addr"}, bus.dmem_addr_o,    addr >> 1);
      step();
      clr_req();
      #1;
      chk({tag, "_busy"}, 16'(bus.req_ready_o),  16'h0);
      chk({tag, "_rv1"},  16'(bus.resp_valid_o), 16'h0);
      chk({tag, "_re1"},  16'(bus.dmem_re_o),    16'h0);
      step();
      chk({tag, "_rv"},    16'(bus.resp_valid_o), 16'h1);
      chk({tag, "_rdata"}, bus.resp_rdata_o,      exp);
      chk({tag, "_rerr"},  16'(bus.resp_err_o),   16'h0);
   endtask

   // Byte store: read at N, merged write at N+1, response at N+2
   task automatic do_sb(input string tag, input logic [15:0] addr, input logic [7:0] b,
                        input logic [15:0] merged);
      set_req(1'b1, 1'b0, 1'b0, addr, {8'h5A, b});
      #1;
      chk({tag, "_re"}, 16'(bus.dmem_re_o), 16'h1);
      chk({tag, "_we"}, 16'(bus.dmem_we_o), 16'h0);
      step();
      clr_req();
      #1;
      chk({tag, "_we1"},   16'(bus.dmem_we_o),    16'h1);
      chk({tag, "_re1"},   16'(bus.dmem_re_o),    16'h0);
      chk({tag, "_wdata"}, bus.dmem_wdata_o,      merged);
      chk({tag, "_addr"},  bus.dmem_addr_o,       addr >> 1);
      chk({tag, "_rv1"},   16'(bus.resp_valid_o), 16'h0);
      step();
      chk({tag, "_rv"},    16'(bus.resp_valid_o), 16'h1);
      chk({tag, "_rdata"}, bus.resp_rdata_o,      16'h0000);
   endtask

   initial begin
      rst_n = 1'b0;
      clr_req();
      repeat (2) step();
      chk("rst_ready", 16'(bus.req_ready_o),  16'h0);
      chk("rst_rv",    16'(bus.resp_valid_o), 16'h0);
      chk("rst_we",    16'(bus.dmem_we_o),    16'h0);
      chk("rst_re",    16'(bus.dmem_re_o),    16'h0);
      rst_n = 1'b1;
      #1;
      chk("rel_ready", 16'(bus.req_ready_o), 16'h1);
      step();

      // 1: half store then half load on the very next cycle
      do_hstore("t1_hs", 16'h0010, 16'hBEEF);
      do_load("t1_lh", 16'h0010, 1'b1, 1'b0, 16'hBEEF);

      // 2: byte lanes and extension
      do_hstore("t2_hs", 16'h0010, 16'h80F0);
      do_load("t2_lb0",  16'h0010, 1'b0, 1'b0, 16'hFFF0);
      do_load("t2_lbu0", 16'h0010, 1'b0, 1'b1, 16'h00F0);
      do_load("t2_lb1",  16'h0011, 1'b0, 1'b0, 16'hFF80);
      do_load("t2_lbu1", 16'h0011, 1'b0, 1'b1, 16'h0080);

      // 3: read-modify-write byte stores, both lanes
      do_hstore("t3_hs", 16'h0020, 16'h1234);
      do_sb("t3_sb1", 16'h0021, 8'hAB, 16'hAB34);
      do_load("t3_lh1", 16'h0020, 1'b1, 1'b0, 16'hAB34);
      do_sb("t3_sb0", 16'h0020, 8'hEF, 16'hABEF);
      do_load("t3_lh0", 16'h0020, 1'b1, 1'b0, 16'hABEF);

      // 4: misaligned half load
      set_req(1'b0, 1'b1, 1'b0, 16'h0013, 16'h0000);
      #1;
      chk("t4_re",    16'(bus.dmem_re_o), 16'h0);
      chk("t4_we",    16'(bus.dmem_we_o), 16'h0);
      chk("t4_hold",  bus.dmem_addr_o,    16'h0010);
      chk("t4_wdata", bus.dmem_wdata_o,   16'h0000);
      step();
      clr_req();
      #1;
      chk("t4_rv",    16'(bus.resp_valid_o), 16'h1);
      chk("t4_err",   16'(bus.resp_err_o),   16'h1);
      chk("t4_rdata", bus.resp_rdata_o,      16'h0000);
      chk("t4_ready", 16'(bus.req_ready_o),  16'h1);
      step();
      chk("t4_rv_end", 16'(bus.resp_valid_o), 16'h0);

      // 5: four back-to-back half stores
      for (int k = 0; k < 4; k++) begin
         set_req(1'b1, 1'b1, 1'b0, 16'(16'h0040 + 2 * k), 16'(16'h1111 * (k + 1)));
         #1;
         chk("t5_ready", 16'(bus.req_ready_o), 16'h1);
         chk("t5_we",    16'(bus.dmem_we_o),   16'h1);
         if (k > 0) chk("t5_rv", 16'(bus.resp_valid_o), 16'h1);
         step();
      end
      clr_req();
      #1;
      chk("t5_rv_last", 16'(bus.resp_valid_o), 16'h1);
      step();
      chk("t5_rv_end", 16'(bus.resp_valid_o), 16'h0);
      for (int k = 0; k < 4; k++)
         chk("t5_mem", mem[8'(8'h20 + k)], 16'(16'h1111 * (k + 1)));
      do_load("t5_lh", 16'h0044, 1'b1, 1'b0, 16'h3333);

      // 6: reset during the RMW write cycle
      do_hstore("t6_hs", 16'h0030, 16'h5566);
      set_req(1'b1, 1'b0, 1'b0, 16'h0031, 16'h0077);
      #1;
      chk("t6_re", 16'(bus.dmem_re_o), 16'h1);
      step();
      clr_req();
      rst_n = 1'b0;
      #1;
      chk("t6_we",    16'(bus.dmem_we_o),   16'h0);
      chk("t6_re1",   16'(bus.dmem_re_o),   16'h0);
      chk("t6_ready", 16'(bus.req_ready_o), 16'h0);
      step();
      chk("t6_rv_rst", 16'(bus.resp_valid_o), 16'h0);
      rst_n = 1'b1;
      #1;
      chk("t6_ready_rel", 16'(bus.req_ready_o), 16'h1);
      step();
      chk("t6_rv_rel", 16'(bus.resp_valid_o), 16'h0);
      chk("t6_mem",    mem[8'h18],            16'h5566);
      do_load("t6_lh", 16'h0030, 1'b1, 1'b0, 16'h5566);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
